// File: rtl/mem_stage.sv
// MEM stage of the LoongArch 5-stage pipeline: waits for the data-SRAM response,
// aligns load data and hands the instruction to WB; drops responses of flushed loads.
module mem_stage #(
  parameter int EBUS_W     = 16,
  parameter int CSR_CTRL_W = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  mem_allow_in,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_alu_result,
  input  logic [4:0]            in_rf_waddr,
  input  logic                  in_rf_we,
  input  logic                  in_res_from_mem,
  input  logic [2:0]            in_ld_op,
  input  logic                  in_req_sent,
  input  logic                  in_res_from_csr,
  input  logic                  in_ertn,
  input  logic [CSR_CTRL_W-1:0] in_csr_ctrl,
  input  logic [EBUS_W-1:0]     in_ebus,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  wb_flush,
  input  logic                  wb_allow_in,
  output logic                  mem_valid,
  output logic                  mem_ready_go,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_final_result,
  output logic [4:0]            out_rf_waddr,
  output logic                  out_rf_we,
  output logic                  out_res_from_csr,
  output logic                  out_ertn,
  output logic [CSR_CTRL_W-1:0] out_csr_ctrl,
  output logic [EBUS_W-1:0]     out_ebus,
  output logic                  fwd_we,
  output logic [4:0]            fwd_waddr,
  output logic [31:0]           fwd_wdata,
  output logic                  fwd_block,
  output logic                  mem_ex_block
);

  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           alu_result;
    logic [4:0]            rf_waddr;
    logic                  rf_we;
    logic                  res_from_mem;
    logic [2:0]            ld_op;
    logic                  res_from_csr;
    logic                  ertn;
    logic [CSR_CTRL_W-1:0] csr_ctrl;
    logic [EBUS_W-1:0]     ebus;
  } inst_t;

  inst_t       inst_q, inst_d;
  logic        mem_valid_q, mem_valid_d;
  logic        need_resp_q, need_resp_d;
  logic        resp_got_q, resp_got_d;
  logic [1:0]  discard_cnt_q, discard_cnt_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        data_ok_live;
  logic        ready_go;
  logic        allow_in;
  logic        accept;
  logic        waiting;
  logic [1:0]  flush_inc;
  logic        discard_dec;
  logic [2:0]  discard_sum;
  logic [31:0] rdata_cur;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;
  logic [31:0] final_result;

  always_comb begin
    data_ok_live = data_sram_data_ok & (discard_cnt_q == 2'd0);
    waiting      = need_resp_q & ~resp_got_q & ~data_ok_live;
    ready_go     = ~waiting;
    allow_in     = ~mem_valid_q | (ready_go & wb_allow_in);
    accept       = in_valid & allow_in & ~wb_flush;

    // Each flushed request still in flight returns one response that must be swallowed.
    flush_inc    = {1'b0, wb_flush & mem_valid_q & waiting}
                 + {1'b0, wb_flush & in_valid & in_req_sent};
    discard_dec  = data_sram_data_ok & (discard_cnt_q != 2'd0);
    discard_sum  = {1'b0, discard_cnt_q} + {1'b0, flush_inc} - {2'b00, discard_dec};
    discard_cnt_d = (discard_sum > 3'd2) ? 2'd2 : discard_sum[1:0];

    inst_d      = inst_q;
    mem_valid_d = mem_valid_q;
    need_resp_d = need_resp_q;
    resp_got_d  = resp_got_q;
    rdata_buf_d = rdata_buf_q;

    if (data_ok_live & mem_valid_q & need_resp_q & ~resp_got_q) begin
      rdata_buf_d = data_sram_rdata;
      resp_got_d  = 1'b1;
    end

    if (wb_flush) begin
      mem_valid_d = 1'b0;
    end else if (accept) begin
      mem_valid_d = 1'b1;
      need_resp_d = in_req_sent;
      resp_got_d  = 1'b0;
      inst_d.pc           = in_pc;
      inst_d.alu_result   = in_alu_result;
      inst_d.rf_waddr     = in_rf_waddr;
      inst_d.rf_we        = in_rf_we;
      inst_d.res_from_mem = in_res_from_mem;
      inst_d.ld_op        = in_ld_op;
      inst_d.res_from_csr = in_res_from_csr;
      inst_d.ertn         = in_ertn;
      inst_d.csr_ctrl     = in_csr_ctrl;
      inst_d.ebus         = in_ebus;
    end else if (allow_in) begin
      mem_valid_d = 1'b0;
    end
  end

  // A response arriving in the current cycle is used directly, no buffering delay.
  always_comb begin
    rdata_cur = resp_got_q ? rdata_buf_q : data_sram_rdata;
    case (inst_q.alu_result[1:0])
      2'd0:    ld_byte = rdata_cur[7:0];
      2'd1:    ld_byte = rdata_cur[15:8];
      2'd2:    ld_byte = rdata_cur[23:16];
      default: ld_byte = rdata_cur[31:24];
    endcase
    ld_half = inst_q.alu_result[1] ? rdata_cur[31:16] : rdata_cur[15:0];
    case (inst_q.ld_op)
      3'b001:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      3'b101:  ld_aligned = {24'd0, ld_byte};
      3'b010:  ld_aligned = {{16{ld_half[15]}}, ld_half};
      3'b110:  ld_aligned = {16'd0, ld_half};
      default: ld_aligned = rdata_cur;
    endcase
    final_result = inst_q.res_from_mem ? ld_aligned : inst_q.alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q        <= '0;
      mem_valid_q   <= 1'b0;
      need_resp_q   <= 1'b0;
      resp_got_q    <= 1'b0;
      discard_cnt_q <= 2'd0;
      rdata_buf_q   <= 32'd0;
    end else begin
      inst_q        <= inst_d;
      mem_valid_q   <= mem_valid_d;
      need_resp_q   <= need_resp_d;
      resp_got_q    <= resp_got_d;
      discard_cnt_q <= discard_cnt_d;
      rdata_buf_q   <= rdata_buf_d;
    end
  end

  assign mem_valid        = mem_valid_q;
  assign mem_ready_go     = ready_go;
  assign mem_allow_in     = allow_in;
  assign out_pc           = inst_q.pc;
  assign out_final_result = final_result;
  assign out_rf_waddr     = inst_q.rf_waddr;
  assign out_rf_we        = inst_q.rf_we & mem_valid_q;
  assign out_res_from_csr = inst_q.res_from_csr;
  assign out_ertn         = inst_q.ertn;
  assign out_csr_ctrl     = inst_q.csr_ctrl;
  assign out_ebus         = inst_q.ebus;
  assign fwd_we           = mem_valid_q & inst_q.rf_we & ~|inst_q.ebus;
  assign fwd_waddr        = inst_q.rf_waddr;
  assign fwd_wdata        = final_result;
  assign fwd_block        = mem_valid_q & ((inst_q.res_from_mem & ~ready_go) | inst_q.res_from_csr);
  assign mem_ex_block     = mem_valid_q & (|inst_q.ebus | inst_q.ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_rf_we, in_res_from_mem, in_req_sent;
  logic        in_res_from_csr, in_ertn, data_sram_data_ok, wb_flush, wb_allow_in;
  logic [31:0] in_pc, in_alu_result, data_sram_rdata;
  logic [4:0]  in_rf_waddr;
  logic [2:0]  in_ld_op;
  logic [79:0] in_csr_ctrl;
  logic [15:0] in_ebus;

  logic        mem_allow_in, mem_valid, mem_ready_go, out_rf_we, out_res_from_csr, out_ertn;
  logic        fwd_we, fwd_block, mem_ex_block;
  logic [31:0] out_pc, out_final_result, fwd_wdata;
  logic [4:0]  out_rf_waddr, fwd_waddr;
  logic [79:0] out_csr_ctrl;
  logic [15:0] out_ebus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.EBUS_W(16), .CSR_CTRL_W(80)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_allow_in(mem_allow_in),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_rf_waddr(in_rf_waddr),
    .in_rf_we(in_rf_we), .in_res_from_mem(in_res_from_mem), .in_ld_op(in_ld_op),
    .in_req_sent(in_req_sent), .in_res_from_csr(in_res_from_csr), .in_ertn(in_ertn),
    .in_csr_ctrl(in_csr_ctrl), .in_ebus(in_ebus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .wb_flush(wb_flush), .wb_allow_in(wb_allow_in),
    .mem_valid(mem_valid), .mem_ready_go(mem_ready_go), .out_pc(out_pc),
    .out_final_result(out_final_result), .out_rf_waddr(out_rf_waddr), .out_rf_we(out_rf_we),
    .out_res_from_csr(out_res_from_csr), .out_ertn(out_ertn), .out_csr_ctrl(out_csr_ctrl),
    .out_ebus(out_ebus), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_block(fwd_block), .mem_ex_block(mem_ex_block)
  );

  // Model: the instruction held in MEM and the number of stale responses still owed.
  bit          m_valid, m_need, m_got, m_we, m_load, m_csr, m_ertn;
  logic [31:0] m_buf, m_pc, m_addr;
  logic [4:0]  m_waddr;
  logic [2:0]  m_op;
  logic [79:0] m_ctl;
  logic [15:0] m_ebus;
  int          m_pend;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align_load(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] a);
    int unsigned v, size;
    case (op)
      3'b001, 3'b101: begin v = (w >> (8 * int'(a))) & 32'hFF; size = 8; end
      3'b010, 3'b110: begin v = (w >> (16 * int'(a[1]))) & 32'hFFFF; size = 16; end
      default: return w;
    endcase
    if (op[2] == 1'b0 && v >= (32'd1 << (size - 1))) v = v - (32'd1 << size);
    return v;
  endfunction

  task automatic idle_inputs();
    reset = 0; in_valid = 0; in_pc = 0; in_alu_result = 0; in_rf_waddr = 0; in_rf_we = 0;
    in_res_from_mem = 0; in_ld_op = 0; in_req_sent = 0; in_res_from_csr = 0; in_ertn = 0;
    in_csr_ctrl = 0; in_ebus = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    wb_flush = 0; wb_allow_in = 1;
  endtask

  task automatic offer_load(input logic [2:0] op, input logic [31:0] addr, input logic req);
    in_valid = 1; in_pc = 32'h1C00_0000 + addr; in_alu_result = addr; in_rf_waddr = 5'd7;
    in_rf_we = 1; in_res_from_mem = 1; in_ld_op = op; in_req_sent = req;
  endtask

  task automatic check_cycle();
    bit ok_live, e_ready, e_allow;
    logic [31:0] e_final;
    #1;
    ok_live = data_sram_data_ok && (m_pend == 0);
    e_ready = !(m_need && !m_got && !ok_live);
    e_allow = !m_valid || (e_ready && wb_allow_in);
    chk("mem_valid", 128'(mem_valid), 128'(m_valid));
    chk("mem_allow_in", 128'(mem_allow_in), 128'(e_allow));
    chk("out_rf_we", 128'(out_rf_we), 128'(m_valid && m_we));
    chk("fwd_we", 128'(fwd_we), 128'(m_valid && m_we && m_ebus == 0));
    chk("fwd_block", 128'(fwd_block), 128'(m_valid && ((m_load && !e_ready) || m_csr)));
    chk("mem_ex_block", 128'(mem_ex_block), 128'(m_valid && (m_ebus != 0 || m_ertn)));
    if (m_valid) begin
      chk("mem_ready_go", 128'(mem_ready_go), 128'(e_ready));
      chk("out_pc", 128'(out_pc), 128'(m_pc));
      chk("out_rf_waddr", 128'(out_rf_waddr), 128'(m_waddr));
      chk("fwd_waddr", 128'(fwd_waddr), 128'(m_waddr));
      chk("out_res_from_csr", 128'(out_res_from_csr), 128'(m_csr));
      chk("out_ertn", 128'(out_ertn), 128'(m_ertn));
      chk("out_csr_ctrl", 128'(out_csr_ctrl), 128'(m_ctl));
      chk("out_ebus", 128'(out_ebus), 128'(m_ebus));
      if (e_ready) begin
        e_final = m_load ? align_load(m_got ? m_buf : data_sram_rdata, m_op, m_addr[1:0]) : m_addr;
        chk("out_final_result", 128'(out_final_result), 128'(e_final));
        chk("fwd_wdata", 128'(fwd_wdata), 128'(e_final));
      end
    end
  endtask

  task automatic advance();
    bit ok_live, e_ready, e_allow;
    int inc, dec;
    ok_live = data_sram_data_ok && (m_pend == 0);
    e_ready = !(m_need && !m_got && !ok_live);
    e_allow = !m_valid || (e_ready && wb_allow_in);
    if (reset) begin
      m_valid = 0; m_need = 0; m_got = 0; m_buf = 0; m_pend = 0; m_pc = 0; m_addr = 0;
      m_waddr = 0; m_we = 0; m_load = 0; m_op = 0; m_csr = 0; m_ertn = 0; m_ctl = 0; m_ebus = 0;
    end else begin
      inc = 0;
      if (wb_flush && m_valid && !e_ready) inc++;
      if (wb_flush && in_valid && in_req_sent) inc++;
      dec = (data_sram_data_ok && m_pend > 0) ? 1 : 0;
      m_pend = m_pend + inc - dec;
      if (m_pend > 2) m_pend = 2;
      if (ok_live && m_valid && m_need && !m_got) begin
        m_buf = data_sram_rdata;
        m_got = 1;
      end
      if (wb_flush) m_valid = 0;
      else if (e_allow && in_valid) begin
        m_valid = 1; m_need = in_req_sent; m_got = 0; m_pc = in_pc; m_addr = in_alu_result;
        m_waddr = in_rf_waddr; m_we = in_rf_we; m_load = in_res_from_mem; m_op = in_ld_op;
        m_csr = in_res_from_csr; m_ertn = in_ertn; m_ctl = in_csr_ctrl; m_ebus = in_ebus;
      end else if (e_allow) m_valid = 0;
    end
    @(posedge clk);
  endtask

  task automatic cycle();
    check_cycle();
    advance();
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    logic [95:0] wide;
    logic [2:0]  ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b101; ops[4] = 3'b110;
    m_pend = 0;
    idle_inputs();
    reset = 1;
    @(negedge clk);
    advance();
    @(negedge clk);
    reset = 1;
    cycle();

    chk("reset_valid", 128'(mem_valid), 128'(0));
    chk("reset_allow", 128'(mem_allow_in), 128'(1));
    chk("reset_result", 128'(out_final_result), 128'(0));

    // Load whose response arrives in its first MEM cycle.
    offer_load(3'b001, 32'h1000_0003, 1);
    cycle();
    data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_FFFF;
    check_cycle();
    chk("ldb_result", 128'(out_final_result), 128'(32'hFFFF_FF80));
    chk("ldb_ready", 128'(mem_ready_go), 128'(1));
    advance(); @(negedge clk); idle_inputs();

    // Late ld.hu, then WB backpressure holding the buffered result.
    offer_load(3'b110, 32'h2000_0002, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("late_block", 128'(fwd_block), 128'(1));
      chk("late_allow", 128'(mem_allow_in), 128'(0));
      advance(); @(negedge clk); idle_inputs();
    end
    data_sram_data_ok = 1; data_sram_rdata = 32'hBEEF_1234; wb_allow_in = 0;
    check_cycle();
    chk("late_result", 128'(out_final_result), 128'(32'h0000_BEEF));
    advance(); @(negedge clk); idle_inputs();
    for (int i = 0; i < 2; i++) begin
      wb_allow_in = 0; data_sram_rdata = 32'h5555_AAAA;
      check_cycle();
      chk("bp_result", 128'(out_final_result), 128'(32'h0000_BEEF));
      chk("bp_allow", 128'(mem_allow_in), 128'(0));
      advance(); @(negedge clk); idle_inputs();
    end
    cycle();

    // Flush with one load waiting and one entering: two responses must be dropped.
    offer_load(3'b000, 32'h0000_0100, 1);
    cycle();
    wb_flush = 1; offer_load(3'b000, 32'h0000_0200, 1);
    cycle();
    chk("flush_valid", 128'(mem_valid), 128'(0));
    offer_load(3'b000, 32'h0000_0300, 1);
    data_sram_data_ok = 1; data_sram_rdata = 32'h1111_1111;
    cycle();
    data_sram_data_ok = 1; data_sram_rdata = 32'h2222_2222;
    check_cycle();
    chk("drop2_ready", 128'(mem_ready_go), 128'(0));
    advance(); @(negedge clk); idle_inputs();
    data_sram_data_ok = 1; data_sram_rdata = 32'h3333_3333;
    check_cycle();
    chk("third_ready", 128'(mem_ready_go), 128'(1));
    chk("third_result", 128'(out_final_result), 128'(32'h3333_3333));
    advance(); @(negedge clk); idle_inputs();

    // Exception passthrough.
    in_valid = 1; in_rf_we = 1; in_ebus = 16'h0080; in_alu_result = 32'hDEAD_0001; in_rf_waddr = 5'd3;
    cycle();
    check_cycle();
    chk("exc_fwd_we", 128'(fwd_we), 128'(0));
    chk("exc_block", 128'(mem_ex_block), 128'(1));
    chk("exc_ebus", 128'(out_ebus), 128'(16'h0080));
    chk("exc_ready", 128'(mem_ready_go), 128'(1));
    advance(); @(negedge clk); idle_inputs();

    // Reset while a load waits and one stale response is owed.
    offer_load(3'b000, 32'h0000_0400, 1);
    cycle();
    wb_flush = 1;
    cycle();
    offer_load(3'b000, 32'h0000_0500, 1);
    cycle();
    reset = 1;
    cycle();
    chk("rst2_valid", 128'(mem_valid), 128'(0));
    chk("rst2_allow", 128'(mem_allow_in), 128'(1));
    chk("rst2_pc", 128'(out_pc), 128'(0));
    offer_load(3'b000, 32'h0000_0600, 1);
    cycle();
    data_sram_data_ok = 1; data_sram_rdata = 32'h6666_6666;
    check_cycle();
    chk("rst2_delivered", 128'(out_final_result), 128'(32'h6666_6666));
    advance(); @(negedge clk); idle_inputs();

    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      in_valid        = $urandom_range(0, 1) == 1;
      in_pc           = $urandom();
      in_alu_result   = $urandom();
      in_rf_waddr     = 5'($urandom_range(0, 31));
      in_rf_we        = $urandom_range(0, 3) != 0;
      in_res_from_mem = $urandom_range(0, 1) == 1;
      in_ld_op        = ops[$urandom_range(0, 4)];
      in_req_sent     = $urandom_range(0, 2) != 0;
      in_res_from_csr = $urandom_range(0, 7) == 0;
      in_ertn         = $urandom_range(0, 15) == 0;
      wide            = {$urandom(), $urandom(), $urandom()};
      in_csr_ctrl     = wide[79:0];
      in_ebus         = ($urandom_range(0, 9) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
      wb_flush        = $urandom_range(0, 19) == 0;
      wb_allow_in     = $urandom_range(0, 9) < 7;
      data_sram_rdata = $urandom();
      data_sram_data_ok = (m_pend > 0 || (m_valid && m_need && !m_got)) && ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
